// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed seven-segment display driver. Scans NUM_DIGITS digits, one
// per refresh slot of 2**REFRESH_LOG2 clock cycles. Each digit is a 5-bit code
// {dp, hex[3:0]}. The hex nibble is decoded to segments a..g. One anode is
// driven per slot. The driver also supports per-digit blanking and PWM
// brightness inside each slot. Inputs are captured into shadow registers only
// at frame boundaries, so a frame on the glass never mixes old and new data.
//
// Parameters
//   NUM_DIGITS    digits scanned (>= 1); width of AN and blank
//   REFRESH_LOG2  slot length is 2**REFRESH_LOG2 clk cycles per digit
//   BRIGHT_W      brightness phase bits taken from the top of the prescaler
//   AN_ACT_LOW    1: an asserted anode is driven as 0
//   SEG_ACT_LOW   1: a lit segment is driven as 0
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   disps       in   5*NUM_DIGITS; digit k = disps[5k+4:5k] = {dp, hex}, digit 0 rightmost
//   blank       in   NUM_DIGITS; 1 = digit k dark for the whole frame
//   bright      in   BRIGHT_W+1; on-time in 1/2**BRIGHT_W slot units, >= 2**BRIGHT_W is full
//   AN          out  NUM_DIGITS anode enables, one-hot-or-none in asserted polarity
//   seven_out   out  8 segment outputs {dp,g,f,e,d,c,b,a}
//   frame_tick  out  1-cycle pulse in the cycle after the shadow registers load
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 16,
  parameter int BRIGHT_W     = 4,
  parameter bit AN_ACT_LOW   = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*NUM_DIGITS-1:0] disps,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [BRIGHT_W:0]       bright,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              seven_out,
  output logic                    frame_tick
);

  // A single-digit display still needs a one-bit index register; it simply
  // never leaves zero.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Pin levels that mean "nothing driven" in the chosen polarities.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACT_LOW}};

  // Scan state.
  logic [REFRESH_LOG2-1:0] cnt;
  logic [IDX_W-1:0]        idx;

  // Frame shadow copies of the display inputs.
  logic [5*NUM_DIGITS-1:0] disps_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [BRIGHT_W:0]       bright_s;

  // Scan decode.
  logic                    slot_end;
  logic                    frame_end;
  logic [BRIGHT_W-1:0]     phase;
  logic [4:0]              cur_code;
  logic                    cur_blank;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [7:0]              seg_next;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // A slot ends when the prescaler is about to wrap. The frame ends when that
  // happens on the last digit.
  assign slot_end  = (cnt == '1);
  assign frame_end = slot_end && (idx == LAST_IDX);

  // The top prescaler bits form a sawtooth across the slot. That sawtooth is
  // compared against the brightness setting to make the PWM on-window.
  assign phase = cnt[REFRESH_LOG2-1 -: BRIGHT_W];

  // Prescaler and digit index. The prescaler wraps by itself. The index steps
  // once per slot and returns to digit 0 after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + REFRESH_LOG2'(1);
      if (slot_end) begin
        if (frame_end) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Shadow registers follow the inputs throughout reset. They are therefore
  // already valid when scanning restarts at digit 0. After that they are
  // refreshed only at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      disps_s  <= disps;
      blank_s  <= blank;
      bright_s <= bright;
    end
  end

  // frame_tick marks the cycle in which freshly loaded shadow data becomes
  // current. Reset takes priority even when it coincides with a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
    end
  end

  // Select the code and blank bit of the digit currently being scanned. A
  // loop is used here because it stays safe when NUM_DIGITS is not a power of
  // two.
  always_comb begin
    cur_code  = disps_s[4:0];
    cur_blank = blank_s[0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code  = disps_s[5*k +: 5];
        cur_blank = blank_s[k];
      end
    end
  end

  // Work out whether the current digit is lit in this cycle. When it is dark,
  // both the anodes and the segments go idle so that nothing ghosts onto a
  // neighbouring digit.
  always_comb begin
    lit      = !cur_blank && ({1'b0, phase} < bright_s);
    an_hot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_hot[k] = lit && (idx == IDX_W'(k));
    end
    seg_next = 8'h00;
    if (lit) begin
      seg_next = {cur_code[4], hex_to_seg(cur_code[3:0])};
    end
  end

  // Registered pin drivers. Polarity is applied here, so all the logic above
  // works in active-high terms.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN        <= AN_OFF;
      seven_out <= SEG_OFF;
    end else begin
      AN        <= an_hot ^ AN_OFF;
      seven_out <= seg_next ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_mux
//
// Testbench for seg7_scan_mux with 4 digits, 16-cycle slots, 2 brightness
// bits and active-low pins. The reference model works from elapsed time since
// the reset release: slot, digit and PWM phase are derived arithmetically from
// that time. Frame data is captured every 64 cycles.
// -----------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int RL    = 4;
  localparam int BW    = 2;
  localparam int SLOT  = 1 << RL;
  localparam int FRAME = SLOT * ND;
  localparam int STEP  = SLOT >> BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [5*ND-1:0] disps;
  logic [ND-1:0] blank;
  logic [BW:0]   bright;
  logic [ND-1:0] AN;
  logic [7:0]    seven_out;
  logic          frame_tick;

  int total  = 0;
  int passed = 0;

  // Reference model state.
  logic [6:0]      seg_tab [16];
  int              t;
  logic [5*ND-1:0] sh_disps;
  logic [ND-1:0]   sh_blank;
  logic [BW:0]     sh_bright;
  logic [ND-1:0]   exp_an;
  logic [7:0]      exp_seg;
  logic            exp_tick;
  int              m_digit;
  logic            m_lit;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_LOG2(RL),
    .BRIGHT_W    (BW),
    .AN_ACT_LOW  (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disps     (disps),
    .blank     (blank),
    .bright    (bright),
    .AN        (AN),
    .seven_out (seven_out),
    .frame_tick(frame_tick)
  );

  // Drive all display inputs together.
  task automatic applyStimulus(input logic [5*ND-1:0] d, input logic [ND-1:0] b,
                               input logic [BW:0] br);
    disps  = d;
    blank  = b;
    bright = br;
  endtask

  // Step one clock edge and work out what the pins should show after it.
  // Sampling happens 1 time unit past the edge.
  task automatic advance();
    logic [4:0] code;
    int phase;
    @(posedge clk);
    if (rst) begin
      t         = 0;
      sh_disps  = disps;
      sh_blank  = blank;
      sh_bright = bright;
      exp_an    = 4'hF;
      exp_seg   = 8'hFF;
      exp_tick  = 1'b0;
      m_lit     = 1'b0;
      m_digit   = 0;
    end else begin
      m_digit  = (t / SLOT) % ND;
      phase    = (t % SLOT) / STEP;
      code     = sh_disps[5*m_digit +: 5];
      m_lit    = !sh_blank[m_digit] && (phase < int'(sh_bright));
      exp_an   = m_lit ? ~(4'b0001 << m_digit) : 4'hF;
      exp_seg  = m_lit ? ~{code[4], seg_tab[code[3:0]]} : 8'hFF;
      exp_tick = ((t % FRAME) == FRAME - 1);
      if (exp_tick) begin
        sh_disps  = disps;
        sh_blank  = blank;
        sh_bright = bright;
      end
      t++;
    end
    #1;
  endtask

  // Run until the model has just loaded a frame. The next output shows that
  // frame's first cycle.
  task automatic sync_frame();
    for (int i = 0; i < FRAME + 2; i++) begin
      advance();
      if (exp_tick) break;
    end
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1;
    applyStimulus('0, '0, 3'd4);
    for (int i = 0; i < 3; i++) begin
      advance();
      total++;
      if (AN !== 4'hF || seven_out !== 8'hFF || frame_tick !== 1'b0) begin
        $display("[TB] FAIL reset_hold: AN=%h seven_out=%h tick=%b, expected AN=f seven_out=ff tick=0",
                 AN, seven_out, frame_tick);
      end else passed++;
    end
    rst = 1'b0;
    advance();
    total++;
    if (AN !== 4'hE || seven_out !== 8'hC0) begin
      $display("[TB] FAIL reset_release: AN=%h seven_out=%h, expected AN=e seven_out=c0", AN, seven_out);
    end else passed++;
    ticks = 0;
    for (int i = 0; i < 2 * FRAME + 12; i++) begin
      advance();
      if (frame_tick === 1'b1) ticks++;
      total++;
      if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL reset_scan t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
    total++;
    if (ticks !== 2) begin
      $display("[TB] FAIL frame_tick_count: got %0d, expected 2", ticks);
    end else passed++;
  endtask

  task automatic test_decode();
    logic [5*ND-1:0] d;
    applyStimulus(20'h00401 | (20'h11 << 5), '0, 3'd4);
    sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      total++;
      if (i < SLOT && (AN !== 4'hE || seven_out !== 8'hF9)) begin
        $display("[TB] FAIL digit0_one: AN=%h seven_out=%h, expected e f9", AN, seven_out);
      end else if (i >= SLOT && i < 2 * SLOT && (AN !== 4'hD || seven_out !== 8'h79)) begin
        $display("[TB] FAIL digit1_dp: AN=%h seven_out=%h, expected d 79", AN, seven_out);
      end else if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL decode_fixed t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
    // Each round shows four consecutive hex codes with random decimal points.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < ND; k++) begin
        d[5*k +: 5] = {1'($urandom), 4'(4 * r + k)};
      end
      applyStimulus(d, '0, 3'd4);
      sync_frame();
      for (int i = 0; i < FRAME; i++) begin
        advance();
        total++;
        if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
          $display("[TB] FAIL decode_hex r=%0d t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                   r, t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
        end else passed++;
      end
    end
  endtask

  task automatic test_tearing();
    logic [5*ND-1:0] old_d;
    old_d = 20'($urandom);
    applyStimulus(old_d, '0, 3'd4);
    sync_frame();
    for (int i = 0; i < SLOT + 4; i++) advance();
    applyStimulus(20'($urandom) ^ old_d ^ 20'hFFFFF, '0, 3'd4);
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance();
      total++;
      if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL tearing t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
  endtask

  task automatic test_brightness();
    logic [BW:0] levels [6];
    int on_cycles;
    int want;
    levels = '{3'd1, 3'd0, 3'd7, 3'd2, 3'd3, 3'd4};
    for (int j = 0; j < 6; j++) begin
      applyStimulus(20'($urandom), '0, levels[j]);
      sync_frame();
      on_cycles = 0;
      for (int i = 0; i < FRAME; i++) begin
        advance();
        if (AN !== 4'hF) on_cycles++;
        total++;
        if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
          $display("[TB] FAIL bright=%0d t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                   levels[j], t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
        end else passed++;
      end
      want = ND * STEP * ((int'(levels[j]) > (1 << BW)) ? (1 << BW) : int'(levels[j]));
      total++;
      if (on_cycles !== want) begin
        $display("[TB] FAIL on_time bright=%0d: lit %0d cycles, expected %0d", levels[j], on_cycles, want);
      end else passed++;
    end
  endtask

  task automatic test_blank();
    applyStimulus(20'($urandom), 4'b0100, 3'd4);
    sync_frame();
    for (int i = 0; i < FRAME; i++) begin
      advance();
      total++;
      if (i >= 2 * SLOT && i < 3 * SLOT && (AN !== 4'hF || seven_out !== 8'hFF)) begin
        $display("[TB] FAIL blank_digit2: AN=%h seven_out=%h, expected f ff", AN, seven_out);
      end else if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL blank t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
    for (int r = 0; r < 3; r++) begin
      applyStimulus(20'($urandom), 4'($urandom), 3'($urandom_range(1, 7)));
      sync_frame();
      for (int i = 0; i < FRAME; i++) begin
        advance();
        total++;
        if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
          $display("[TB] FAIL blank_rand t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                   t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
        end else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(20'($urandom), '0, 3'd4);
    sync_frame();
    for (int i = 0; i < 2 * SLOT + 5; i++) advance();
    rst = 1'b1;
    advance();
    total++;
    if (AN !== 4'hF || seven_out !== 8'hFF || frame_tick !== 1'b0) begin
      $display("[TB] FAIL reset_mid: AN=%h seven_out=%h tick=%b, expected f ff 0", AN, seven_out, frame_tick);
    end else passed++;
    rst = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      advance();
      total++;
      if (i < SLOT && AN !== 4'hE) begin
        $display("[TB] FAIL restart_digit0 i=%0d: AN=%h, expected e", i, AN);
      end else if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL restart t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) disps = 20'($urandom);
      if ($urandom_range(0, 59) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bright = 3'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      advance();
      total++;
      if (AN !== exp_an || seven_out !== exp_seg || frame_tick !== exp_tick) begin
        $display("[TB] FAIL random t=%0d: AN=%h seven_out=%h tick=%b, expected %h %h %b",
                 t, AN, seven_out, frame_tick, exp_an, exp_seg, exp_tick);
      end else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    t = 0;
    rst = 1'b1;
    applyStimulus('0, '0, 3'd4);
    test_reset();
    test_decode();
    test_tearing();
    test_brightness();
    test_blank();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
